instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
- REQ-001 Parameter: FIFO_DEPTH, default 4, number of buffered encoded words (power of 2, >=2).
- REQ-002 Parameter: BASE_ADDR, default 32'h0000_0000, first instruction-memory byte address written.
- REQ-003 clk  input  1  single clock; all state updates on rising edge.
- REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- REQ-005 clear  input  1  synchronous flush: empty FIFO, reload address to BASE_ADDR.
- REQ-006 in_valid  input  1  instruction request valid.
- REQ-007 in_ready  output  1  encoder can accept request; high when FIFO not full.
- REQ-008 in_kind  input  4  0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LW,6 SW,7 BEQ,8 ADDI,9 J,10-15 illegal.
- REQ-009 in_rs, in_rt, in_rd  input  5 each  register fields.
- REQ-010 in_imm  input  16  immediate/offset field.
- REQ-011 in_target  input  26  jump target field.
- REQ-012 imem_we  output  1  instruction-memory write strobe.
- REQ-013 imem_ready  input  1  memory accepts write this cycle.
- REQ-014 imem_addr  output  32  byte address of current write.
- REQ-015 imem_wdata  output  32  encoded instruction word.
- REQ-016 word_count  output  16  words written to memory since reset/clear, saturating at 16'hFFFF.

Function
- REQ-017 Request accepted on a rising edge where in_valid && in_ready; fields captured that edge only.
- REQ-018 R-type (kinds 0-4) SHALL encode {6'h00, rs, rt, rd, 5'h00, funct}, funct = 20/22/24/25/2A hex respectively.
- REQ-019 I-type SHALL encode {op, rs, rt, imm}: LW op 6'h23, SW 6'h2B, BEQ 6'h04, ADDI 6'h08.
- REQ-020 J SHALL encode {6'h02, target}; unused input fields ignored for every kind.
- REQ-021 Encoding is combinational on inputs; encoded word pushed into FIFO on acceptance.
- REQ-022 imem_we SHALL equal FIFO non-empty; imem_wdata SHALL be FIFO head; imem_addr SHALL be current address register.
- REQ-023 Write completes on edge with imem_we && imem_ready: pop head, address += 4, word_count += 1 (saturating).
- REQ-024 Minimum latency: word accepted at edge N appears on imem_we/imem_wdata after edge N (same cycle as FIFO non-empty), completes at edge N+1 if imem_ready.
- REQ-025 Address wraps modulo 2^32 (32'hFFFF_FFFC + 4 -> 0).
- REQ-026 Simultaneous push and pop when full: in_ready low, no push; pop proceeds; in_ready high next cycle.
- REQ-027 Simultaneous push and pop when non-full, non-empty: occupancy unchanged, order preserved (FIFO order strict).
- REQ-028 Push into empty FIFO: no bypass; word visible on imem_wdata the cycle after acceptance.
- REQ-029 clear has priority over push and pop in the same cycle: accepted request and pending write discarded, word_count to 0.
- REQ-030 in_ready SHALL be low while clear is high.

Reset
- REQ-031 On rst_n low at a rising edge: FIFO empty, imem_we 0, imem_addr BASE_ADDR, word_count 0, err 0 (when present).
- REQ-032 Reset mid-operation discards all buffered words; no write strobe the cycle after reset edge.
- REQ-033 in_ready SHALL be low while rst_n is low.

Configuration
- REQ-034 Macro ENC_ILLEGAL_CHK_EN.
- REQ-035 Defined: output err (1 bit) added; illegal kind accepted, not pushed, err pulses high one cycle after acceptance edge; address unaffected.
- REQ-036 Not defined: no err port; illegal kind encoded as NOP 32'h0000_0000 and written like any word.

Verification
- REQ-037 Reset, then ADD rs=1 rt=2 rd=3 -> imem_wdata 32'h0022_1820 at imem_addr BASE_ADDR, word_count 1.
- REQ-038 LW rs=4 rt=5 imm=16'h0010, then J target=26'h000_0040 -> words 32'h8C85_0010 @0, 32'h0800_0040 @4.
- REQ-039 imem_ready held 0, push 5 requests with depth 4 -> in_ready low after 4th; release -> 4 words in order, 5th accepted after first pop.
- REQ-040 BASE_ADDR 32'hFFFF_FFFC, two SUB writes -> addresses 32'hFFFF_FFFC then 32'h0000_0000.
- REQ-041 clear asserted with 3 buffered and push pending -> FIFO empty, imem_we 0 next cycle, imem_addr BASE_ADDR, word_count 0.
- REQ-042 in_kind 4'hF with ENC_ILLEGAL_CHK_EN -> err one-cycle pulse, no write; without macro -> 32'h0000_0000 written, address += 4.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes MIPS-style instruction requests into 32-bit words and streams them
// through a small FIFO into instruction memory at consecutive word addresses.
// Optional feature: define ENC_ILLEGAL_CHK_EN to add an err output that flags illegal kinds
// (those are then dropped); otherwise illegal kinds are written as NOP 32'h0000_0000.
module instr_encoder #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    output logic        imem_we,
    input  logic        imem_ready,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic [15:0] word_count
`ifdef ENC_ILLEGAL_CHK_EN
    ,
    output logic        err
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [15:0]   wcnt_q, wcnt_d;
    logic [31:0]   enc;
    logic          legal, full, accept, push, pop;
`ifdef ENC_ILLEGAL_CHK_EN
    logic          err_q, err_d;
`endif

    // Instruction encoding from the request fields; illegal kinds fall through to zero
    always_comb begin
        enc   = 32'h0000_0000;
        legal = 1'b1;
        case (in_kind)
            4'd0:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h20};
            4'd1:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h22};
            4'd2:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h24};
            4'd3:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h25};
            4'd4:    enc = {6'h00, in_rs, in_rt, in_rd, 5'h00, 6'h2A};
            4'd5:    enc = {6'h23, in_rs, in_rt, in_imm};
            4'd6:    enc = {6'h2B, in_rs, in_rt, in_imm};
            4'd7:    enc = {6'h04, in_rs, in_rt, in_imm};
            4'd8:    enc = {6'h08, in_rs, in_rt, in_imm};
            4'd9:    enc = {6'h02, in_target};
            default: legal = 1'b0;
        endcase
    end

    // Handshakes and next-state; clear and reset override both push and pop
    always_comb begin
        full     = cnt_q == (AW + 1)'(FIFO_DEPTH);
        in_ready = rst_n && !clear && !full;
        accept   = in_valid && in_ready;
`ifdef ENC_ILLEGAL_CHK_EN
        push     = accept && legal;
        err_d    = accept && !legal;
`else
        push     = accept;
`endif
        pop      = imem_we && imem_ready;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        addr_d   = pop ? addr_q + 32'd4 : addr_q;
        wcnt_d   = (pop && wcnt_q != 16'hFFFF) ? wcnt_q + 16'd1 : wcnt_q;
    end

    // FIFO storage; contents need no reset because occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= enc;
    end

    // Control state with synchronous active-low reset and synchronous flush
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            addr_q   <= BASE_ADDR;
            wcnt_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wcnt_q   <= wcnt_d;
        end
    end

`ifdef ENC_ILLEGAL_CHK_EN
    // One-cycle error pulse following acceptance of an illegal kind
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign err = err_q;
`endif

    assign imem_we    = cnt_q != '0;
    assign imem_wdata = mem_q[rd_ptr_q];
    assign imem_addr  = addr_q;
    assign word_count = wcnt_q;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized and directed checks of instr_encoder against a queue-based reference model.
module tb_instr_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, imem_ready = 1'b0;
    logic        in_ready, imem_we;
    logic [3:0]  in_kind = 4'd0;
    logic [4:0]  in_rs = 5'd0, in_rt = 5'd0, in_rd = 5'd0;
    logic [15:0] in_imm = 16'd0;
    logic [25:0] in_target = 26'd0;
    logic [31:0] imem_addr, imem_wdata;
    logic [15:0] word_count;
`ifdef ENC_ILLEGAL_CHK_EN
    logic        err;
`endif

    instr_encoder #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .in_target(in_target), .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .word_count(word_count)
`ifdef ENC_ILLEGAL_CHK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int          n_err = 0, n_chk = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_addr = BASE;
    int          m_cnt = 0;
    bit          m_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_enc(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                                            input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
        logic [5:0] functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] ops    [4] = '{6'h23, 6'h2B, 6'h04, 6'h08};
        if (k <= 4) return {6'h00, s, t, d, 5'h00, functs[k]};
        if (k <= 8) return {ops[k-5], s, t, im};
        if (k == 9) return {6'h02, tg};
        return 32'h0;
    endfunction

    task automatic step(input bit r, input bit c, input bit v, input logic [3:0] k, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [15:0] im,
                        input logic [25:0] tg, input bit rdy);
        bit exp_ready, legal;
        @(negedge clk);
        rst_n = r; clear = c; in_valid = v; in_kind = k; in_rs = s; in_rt = t; in_rd = d;
        in_imm = im; in_target = tg; imem_ready = rdy;
        #1;
        exp_ready = r && !c && m_q.size() < DEPTH;
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        chk("imem_we", {31'd0, imem_we}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) chk("imem_wdata", imem_wdata, m_q[0]);
        chk("imem_addr", imem_addr, m_addr);
        chk("word_count", {16'd0, word_count}, m_cnt);
`ifdef ENC_ILLEGAL_CHK_EN
        chk("err", {31'd0, err}, {31'd0, m_err});
        legal = k <= 9;
`else
        legal = 1;
`endif
        if (!r || c) begin
            m_q.delete(); m_addr = BASE; m_cnt = 0; m_err = 0;
        end else begin
            m_err = v && exp_ready && !legal;
            if (m_q.size() != 0 && rdy) begin
                void'(m_q.pop_front());
                m_addr = m_addr + 32'd4;
                if (m_cnt < 65535) m_cnt++;
            end
            if (v && exp_ready && legal) m_q.push_back(ref_enc(k, s, t, d, im, tg));
        end
    endtask

    task automatic idle(input bit rdy);
        step(1, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, rdy);
    endtask

    task automatic flush();
        step(1, 1, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
    endtask

    initial begin
        step(0, 0, 0, 4'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 0);
        idle(0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_addr", imem_addr, BASE);
        step(1, 0, 1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 26'd0, 0);
        idle(0);
        chk("add_word", imem_wdata, 32'h0022_1820);
        chk("add_addr", imem_addr, BASE);
        idle(1);
        idle(0);
        chk("add_count", {16'd0, word_count}, 32'd1);

        flush();
        step(1, 0, 1, 4'd5, 5'd4, 5'd5, 5'd0, 16'h0010, 26'd0, 0);
        step(1, 0, 1, 4'd9, 5'd0, 5'd0, 5'd0, 16'd0, 26'h000_0040, 0);
        idle(0);
        chk("lw_word", imem_wdata, 32'h8C85_0010);
        chk("lw_addr", imem_addr, BASE);
        idle(1);
        idle(0);
        chk("j_word", imem_wdata, 32'h0800_0040);
        chk("j_addr", imem_addr, 32'hFFFF_FFFC);
        idle(1);
        idle(0);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_count", {16'd0, word_count}, 32'd2);

        flush();
        for (int i = 0; i < 4; i++) step(1, 0, 1, 4'd1, 5'(i), 5'd7, 5'd9, 16'd0, 26'd0, 0);
        step(1, 0, 1, 4'd1, 5'd4, 5'd7, 5'd9, 16'd0, 26'd0, 0);
        chk("full_ready", {31'd0, in_ready}, 32'd0);
        step(1, 0, 1, 4'd1, 5'd4, 5'd7, 5'd9, 16'd0, 26'd0, 1);
        chk("full_pop_ready", {31'd0, in_ready}, 32'd0);
        step(1, 0, 1, 4'd1, 5'd4, 5'd7, 5'd9, 16'd0, 26'd0, 1);
        chk("after_pop_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) idle(1);

        flush();
        for (int i = 0; i < 3; i++) step(1, 0, 1, 4'd2, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 0);
        step(1, 1, 1, 4'd3, 5'd1, 5'd1, 5'd1, 16'd0, 26'd0, 1);
        chk("clr_ready", {31'd0, in_ready}, 32'd0);
        idle(0);
        chk("clr_we", {31'd0, imem_we}, 32'd0);
        chk("clr_addr", imem_addr, BASE);
        chk("clr_count", {16'd0, word_count}, 32'd0);

        step(1, 0, 1, 4'hF, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'h3FF_FFFF, 0);
        idle(0);
`ifdef ENC_ILLEGAL_CHK_EN
        chk("ill_err", {31'd0, err}, 32'd1);
        chk("ill_we", {31'd0, imem_we}, 32'd0);
`else
        chk("ill_we", {31'd0, imem_we}, 32'd1);
        chk("ill_nop", imem_wdata, 32'h0000_0000);
`endif
        idle(1);
        idle(0);
`ifdef ENC_ILLEGAL_CHK_EN
        chk("ill_addr", imem_addr, BASE);
`else
        chk("ill_addr", imem_addr, BASE + 32'd4);
`endif

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] k;
            k = ($urandom % 8 == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            step(($urandom % 64) != 0, ($urandom % 40) == 0, ($urandom % 10) < 7, k,
                 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 26'($urandom),
                 ($urandom % 10) < 6);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
